// File: rtl/full_handshake_tx_if.sv
// Bus bundle between the local source logic, the transmitter and the remote
// four-phase receiver. master is the transmitter's view, slave is the environment's.
interface full_handshake_tx_if #(
  parameter int DW = 32
);
  logic          req_i;
  logic [DW-1:0] req_data_i;
  logic          idle_o;
  logic          done_o;
  logic          ack_i;
  logic          req_o;
  logic [DW-1:0] req_data_o;

  modport master (
    input  req_i, req_data_i, ack_i,
    output idle_o, done_o, req_o, req_data_o
  );

  modport slave (
    output req_i, req_data_i, ack_i,
    input  idle_o, done_o, req_o, req_data_o
  );
endinterface

// File: rtl/full_handshake_tx.sv
// Source-domain side of a four-phase req/ack CDC handshake: captures one word,
// raises req, and walks req=1, ack=1, req=0, ack=0 before accepting the next word.
module full_handshake_tx #(
  parameter int DW = 32
) (
  input  logic               clk,
  input  logic               rst,
  full_handshake_tx_if.master bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'b001,
    ASSERT   = 3'b010,
    DEASSERT = 3'b100
  } state_t;

  state_t        state_q, state_d;
  logic          req_q, req_d;
  logic [DW-1:0] data_q, data_d;
  logic          ack_d_q, ack_s_q;
  logic          idle;

  // ack_i is asynchronous to clk, so only the second synchroniser stage is trusted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_d_q <= 1'b0;
      ack_s_q <= 1'b0;
    end else begin
      ack_d_q <= bus.ack_i;
      ack_s_q <= ack_d_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
    end
  end

  // A still-high ack after a reset blocks acceptance so a stale ack cannot complete a new word.
  assign idle = (state_q == IDLE) && !ack_s_q;

  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (bus.req_i && idle) begin
          data_d  = bus.req_data_i;
          req_d   = 1'b1;
          state_d = ASSERT;
        end
      end
      ASSERT: begin
        req_d = 1'b1;
        if (ack_s_q) begin
          req_d   = 1'b0;
          state_d = DEASSERT;
        end
      end
      DEASSERT: begin
        if (!ack_s_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // done is flagged in the DEASSERT-to-IDLE cycle, so it never overlaps an acceptance.
  assign bus.done_o     = (state_q == DEASSERT) && !ack_s_q;
  assign bus.idle_o     = idle;
  assign bus.req_o      = req_q;
  assign bus.req_data_o = data_q;

endmodule

// File: tb/tb_full_handshake_tx.sv
// Scoreboard bench for full_handshake_tx: random words and receiver latencies,
// with a monitor checking captured data and handshake timing against ack edges.
module tb_full_handshake_tx;

  localparam int DW = 32;

  logic clk;
  logic rst;
  full_handshake_tx_if #(.DW(DW)) bus();

  full_handshake_tx #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int checks = 0;
  int fails  = 0;
  int rxDelay = 4;
  int doneCount = 0;
  int expDone = 0;
  logic [DW-1:0] expQ[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Receiver model: follows req with ack after rxDelay observed cycles.
  initial begin
    int cnt;
    cnt = 0;
    bus.ack_i = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.req_o !== bus.ack_i) begin
        cnt++;
        if (cnt >= rxDelay) begin
          #1 bus.ack_i = bus.req_o;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: pops expected words on req rise and checks timing against ack edges.
  initial begin
    int cyc, ackRiseObs, ackFallObs, lastDoneCyc, idleCheckCyc;
    logic prevReq, prevAck, pendingDone, doneExp;
    logic [DW-1:0] curWord;
    cyc = 0; ackRiseObs = -100; ackFallObs = -100; lastDoneCyc = -100; idleCheckCyc = -1;
    prevReq = 1'b0; prevAck = 1'b0; pendingDone = 1'b0; curWord = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.ack_i && !prevAck) ackRiseObs = cyc;
      if (!bus.ack_i && prevAck) ackFallObs = cyc;
      prevAck = bus.ack_i;
      if (rst) begin
        prevReq = 1'b0;
        pendingDone = 1'b0;
        idleCheckCyc = -1;
      end else begin
        if (bus.req_o && !prevReq) begin
          checkOutput("req_rise_has_word", DW'(expQ.size() != 0), 1);
          if (expQ.size() != 0) begin
            curWord = expQ.pop_front();
            checkOutput("req_data_capture", bus.req_data_o, curWord);
          end
          checkOutput("accept_after_done_gap", DW'((cyc - lastDoneCyc) >= 2), 1);
        end else if (bus.req_o && prevReq) begin
          checkOutput("req_data_stable", bus.req_data_o, curWord);
        end else if (!bus.req_o && prevReq) begin
          checkOutput("req_fall_latency", DW'(cyc), DW'(ackRiseObs + 2));
          pendingDone = 1'b1;
        end
        doneExp = pendingDone && !bus.ack_i && (cyc == ackFallObs + 1);
        if (bus.done_o || doneExp) begin
          checkOutput("done_pulse", DW'(bus.done_o), DW'(doneExp));
          if (bus.done_o && doneExp) begin
            doneCount++;
            lastDoneCyc = cyc;
            pendingDone = 1'b0;
            idleCheckCyc = cyc + 1;
          end
        end
        if (cyc == idleCheckCyc) checkOutput("idle_after_done", DW'(bus.idle_o), 1);
        prevReq = bus.req_o;
      end
    end
  end

  // Offers one word and holds req_i until the block accepts it; req_i is left high.
  task automatic applyStimulus(input logic [DW-1:0] word);
    logic ok;
    ok = 1'b0;
    @(negedge clk);
    bus.req_data_i = word;
    bus.req_i = 1'b1;
    expQ.push_back(word);
    for (int i = 0; i < 2000; i++) begin
      if (bus.idle_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("accept_wait", DW'(ok), 1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("req_rise_latency", DW'(bus.req_o), 1);
  endtask

  task automatic waitDone(input int target);
    for (int i = 0; i < 3000; i++) begin
      if (doneCount >= target) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checkOutput("done_count", DW'(doneCount), DW'(target));
  endtask

  task automatic waitAck(input logic level);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.ack_i === level) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("ack_wait", DW'(ok), 1);
  endtask

  initial begin
    logic [DW-1:0] w;
    rst = 1'b0;
    bus.req_i = 1'b0;
    bus.req_data_i = '0;
    #2 rst = 1'b1;
    #2;
    checkOutput("reset_req_o", DW'(bus.req_o), 0);
    checkOutput("reset_done_o", DW'(bus.done_o), 0);
    checkOutput("reset_idle_o", DW'(bus.idle_o), 1);
    checkOutput("reset_data_o", bus.req_data_o, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    $display("[TB] basic transfer");
    repeat (5) @(negedge clk);
    applyStimulus(32'hDEADBEEF);
    bus.req_i = 1'b0;
    expDone++;
    waitDone(expDone);

    $display("[TB] back-to-back words");
    applyStimulus(32'h00000001);
    applyStimulus(32'h00000002);
    bus.req_i = 1'b0;
    expDone += 2;
    waitDone(expDone);

    $display("[TB] busy-time request");
    rxDelay = 6;
    applyStimulus(32'h12345678);
    bus.req_i = 1'b0;
    @(negedge clk);
    bus.req_data_i = 32'h00000055;
    bus.req_i = 1'b1;
    @(negedge clk);
    bus.req_i = 1'b0;
    expDone++;
    waitDone(expDone);

    $display("[TB] reset mid-ASSERT with ack high");
    rxDelay = 12;
    applyStimulus(32'hA5A50001);
    bus.req_i = 1'b0;
    waitAck(1'b1);
    @(posedge clk);
    #2 checkOutput("req_before_reset", DW'(bus.req_o), 1);
    #1 rst = 1'b1;
    #1;
    checkOutput("async_rst_req_o", DW'(bus.req_o), 0);
    checkOutput("async_rst_done_o", DW'(bus.done_o), 0);
    checkOutput("async_rst_data_o", bus.req_data_o, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("idle_stale_ack", DW'(bus.idle_o), 0);
    bus.req_data_i = 32'h00000077;
    bus.req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stale_no_capture", DW'(bus.req_o), 0);
    end
    checkOutput("stale_data_hold", bus.req_data_o, 0);
    bus.req_i = 1'b0;
    waitAck(1'b0);
    checkOutput("idle_ack_fall_1", DW'(bus.idle_o), 0);
    @(negedge clk);
    checkOutput("idle_ack_fall_2", DW'(bus.idle_o), 1);
    rxDelay = 4;
    applyStimulus(32'hCAFEF00D);
    bus.req_i = 1'b0;
    expDone++;
    waitDone(expDone);

    $display("[TB] slow receiver");
    rxDelay = 100;
    applyStimulus(32'h0BADF00D);
    bus.req_i = 1'b0;
    expDone++;
    waitDone(expDone);

    $display("[TB] randomized transfers");
    for (int n = 0; n < 16; n++) begin
      rxDelay = $urandom_range(1, 8);
      w = $urandom;
      applyStimulus(w);
      if ($urandom_range(0, 3) == 0) begin
        w = $urandom;
        applyStimulus(w);
        expDone++;
      end
      bus.req_i = 1'b0;
      expDone++;
      waitDone(expDone);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    checkOutput("queue_empty", DW'(expQ.size()), 0);
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/full_handshake_tx.md
Name: full_handshake_tx

Overview:
- Transmit-side partner of the four-phase clock-domain-crossing handshake receiver.
- Lives in the source clock domain. Accepts one DW-bit word from local logic, then drives req_o and req_data_o across to the receiver.
- Completes the full four-phase sequence against the receiver's ack (req=1, ack=1, req=0, ack=0), then reports completion and accepts the next word.

Parameters:
- DW, 32, width of the transferred data word.

Ports:
- clk  input  1  TX-domain clock; the only clock in the block.
- rst  input  1  Reset. Asynchronous and active-high (one clock; reset is asynchronous and active-high).
- req_i  input  1  Local request: transfer req_data_i. Sampled only while idle_o=1.
- req_data_i  input  DW  Local data word, captured in the cycle req_i and idle_o are both 1.
- idle_o  output  1  Block can accept a new word this cycle.
- done_o  output  1  One-cycle pulse: the four-phase handshake has fully completed.
- ack_i  input  1  Receiver acknowledge. Asynchronous to clk.
- req_o  output  1  Request to the receiver, driven straight from a flop.
- req_data_o  output  DW  Data to the receiver, driven straight from a register.

Behaviour:
- Reset (async assert, async release on clk) sets:
  - state=IDLE
  - req_o=0, req_data_o=0, done_o=0
  - both ack synchroniser flops=0
  - idle_o=1 (once ack_s=0)
- ack synchroniser:
  - ack_i passes through two flops: ack_d, then ack_s.
  - Only ack_s is used by the block.
  - An ack_i edge is therefore visible in ack_s 2 rising edges after it occurs.
- States, one-hot: IDLE, ASSERT, DEASSERT.
- idle_o is combinational: (state==IDLE) and (ack_s==0).
- IDLE:
  - If req_i=1 and idle_o=1 at edge N:
    - req_data_o is loaded with req_data_i.
    - req_o becomes 1.
    - state moves to ASSERT.
    - All three take effect at edge N.
  - Otherwise the block holds its state.
  - req_i while idle_o=0 is ignored, not queued. Local logic must hold req_i until it sees idle_o=1.
- ASSERT:
  - req_o is held at 1 and req_data_o is held stable.
  - When ack_s=1: req_o goes to 0 and state moves to DEASSERT.
  - req_o therefore falls on the 3rd rising edge after ack_i rises.
- DEASSERT:
  - req_o is held at 0.
  - When ack_s=0: state moves to IDLE and done_o=1 for exactly one cycle.
  - This happens on the 3rd edge after ack_i falls.
- req_data_o is never cleared after reset. It holds the last captured word until the next capture, so it is stable through the receiver's whole sampling window.
- Minimum round trip: 1 cycle from acceptance to req_o=1, plus receiver latency, plus 3 cycles per ack edge.
- A new word can be accepted in the cycle after done_o, at the earliest.
- Stale ack:
  - If ack_s=1 while in IDLE (typically TX was reset mid-transfer while the receiver was still acknowledging), idle_o stays 0.
  - No new req is raised until ack_s returns to 0.
  - This prevents a false completion.
- Reset mid-operation:
  - req_o drops to 0 asynchronously and the FSM returns to IDLE.
  - The receiver sees req fall and releases ack. The stale-ack rule above then gates restart.
- ack_i glitch or early drop in ASSERT: ack_s must actually be 1 before the block leaves ASSERT. A pulse shorter than one clk period may be missed, and the block then keeps waiting. The receiver protocol guarantees ack is held until req falls.
- Illegal or unused state encodings recover to IDLE on the next edge with req_o=0.
- done_o and the next acceptance never coincide. done_o is asserted only in the DEASSERT-to-IDLE cycle.

Test Plan:
- Basic transfer:
  - Stimulus: req_i=1 with req_data_i=0xDEADBEEF at edge 10; model receiver raises ack_i 4 cycles after req_o rises and drops it 4 cycles after req_o falls.
  - Required: req_o=1 from edge 10; req_data_o=0xDEADBEEF stable until req_o falls; req_o falls 3 edges after ack_i rises; done_o one-cycle pulse 3 edges after ack_i falls; idle_o=1 again the next cycle.
- Back-to-back words:
  - Stimulus: req_i held 1 with 0x00000001 then 0x00000002.
  - Required: the second word is captured only in the cycle after done_o; exactly 2 done_o pulses; req_data_o sequence is 0x1, then 0x2.
- Busy-time request:
  - Stimulus: pulse req_i for 1 cycle with data 0x55 while in ASSERT.
  - Required: the pulse is ignored; req_data_o is unchanged; no extra handshake occurs.
- Reset mid-ASSERT while ack_i=1:
  - Required: req_o=0 immediately and idle_o=0.
  - Stimulus: assert req_i=1 while ack_i is still 1.
  - Required: no capture; after ack_i drops, idle_o=1 two edges later; the next transfer completes normally.
- Slow receiver:
  - Stimulus: ack_i raised 100 cycles after req_o.
  - Required: req_o and req_data_o are held for the full 100+3 cycles; done_o does not pulse early.
- Async reset:
  - Stimulus: assert rst between clock edges.
  - Required: req_o=0, done_o=0, req_data_o=0 before the next clk edge.
